// File: rtl/rc4_prga_decrypt_pkg.sv
// RC4 PRGA shared definitions: FSM state encoding and the plaintext character-class helper.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INC_I  = 4'd1,
        ST_RD_SI  = 4'd2,
        ST_LAT_SI = 4'd3,
        ST_RD_SJ  = 4'd4,
        ST_LAT_SJ = 4'd5,
        ST_WR_I   = 4'd6,
        ST_WR_J   = 4'd7,
        ST_RD_F   = 4'd8,
        ST_RD_FW  = 4'd9,
        ST_LAT_F  = 4'd10,
        ST_CHECK  = 4'd11,
        ST_D_REQ  = 4'd12,
        ST_D_WAIT = 4'd13,
        ST_NEXT   = 4'd14,
        ST_END    = 4'd15
    } prga_state_t;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    // Lower-case letter or space.
    function automatic logic is_plain_char(input logic [7:0] b);
        is_plain_char = ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Memory-side bus of the RC4 decrypt stage: S-RAM port, encrypted-message ROM port
// and the D-memory write handshake.
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic [7:0]        s_addr;
    logic [7:0]        s_rdata;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [MSG_AW-1:0] e_addr;
    logic [7:0]        e_rdata;
    logic [MSG_AW-1:0] d_addr;
    logic [7:0]        d_wr_data;
    logic              d_wr_start;
    logic              d_wr_done;

    modport master (
        output s_addr, s_wdata, s_wren, e_addr, d_addr, d_wr_data, d_wr_start,
        input  s_rdata, e_rdata, d_wr_done
    );

    modport slave (
        input  s_addr, s_wdata, s_wren, e_addr, d_addr, d_wr_data, d_wr_start,
        output s_rdata, e_rdata, d_wr_done
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decrypt stage running over an S-RAM already set up by KSA.
// Optional build macro RC4_CHAR_CHECK_EN aborts the pass on a byte that is not 'a'-'z' or space.
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    output logic               done,
    output logic               fail,
    rc4_prga_decrypt_if.master mem
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    prga_state_t       state_r;
    logic [7:0]        i_r;
    logic [7:0]        j_r;
    logic [MSG_AW-1:0] k_r;
    logic [7:0]        si_r;
    logic [7:0]        sj_r;
    logic [7:0]        dec_r;

    logic [7:0]        s_addr_r;
    logic [7:0]        s_wdata_r;
    logic              s_wren_r;
    logic [MSG_AW-1:0] e_addr_r;
    logic [MSG_AW-1:0] d_addr_r;
    logic [7:0]        d_wr_data_r;
    logic              d_wr_start_r;
    logic              done_r;
`ifdef RC4_CHAR_CHECK_EN
    logic              fail_r;
`endif

    // Bus outputs are set on the transition into the state that presents them, so every
    // memory address is stable for the whole state in which the memory samples it.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r      <= ST_IDLE;
            i_r          <= 8'd0;
            j_r          <= 8'd0;
            k_r          <= '0;
            si_r         <= 8'd0;
            sj_r         <= 8'd0;
            dec_r        <= 8'd0;
            s_addr_r     <= 8'd0;
            s_wdata_r    <= 8'd0;
            s_wren_r     <= 1'b0;
            e_addr_r     <= '0;
            d_addr_r     <= '0;
            d_wr_data_r  <= 8'd0;
            d_wr_start_r <= 1'b0;
            done_r       <= 1'b0;
`ifdef RC4_CHAR_CHECK_EN
            fail_r       <= 1'b0;
`endif
        end else begin
            s_wren_r     <= 1'b0;
            d_wr_start_r <= 1'b0;
            done_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        i_r     <= 8'd0;
                        j_r     <= 8'd0;
                        k_r     <= '0;
                        state_r <= ST_INC_I;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INC_I: begin
                    i_r      <= i_r + 8'd1;
                    s_addr_r <= i_r + 8'd1;
                    state_r  <= ST_RD_SI;
                end
                ST_RD_SI: begin
                    state_r <= ST_LAT_SI;
                end
                ST_LAT_SI: begin
                    si_r     <= mem.s_rdata;
                    j_r      <= j_r + mem.s_rdata;
                    s_addr_r <= j_r + mem.s_rdata;
                    state_r  <= ST_RD_SJ;
                end
                ST_RD_SJ: begin
                    state_r <= ST_LAT_SJ;
                end
                ST_LAT_SJ: begin
                    sj_r      <= mem.s_rdata;
                    s_addr_r  <= i_r;
                    s_wdata_r <= mem.s_rdata;
                    s_wren_r  <= 1'b1;
                    state_r   <= ST_WR_I;
                end
                ST_WR_I: begin
                    s_addr_r  <= j_r;
                    s_wdata_r <= si_r;
                    s_wren_r  <= 1'b1;
                    state_r   <= ST_WR_J;
                end
                // The swap does not change si+sj, so the pre-swap copies index f correctly.
                ST_WR_J: begin
                    s_addr_r <= si_r + sj_r;
                    e_addr_r <= k_r;
                    state_r  <= ST_RD_F;
                end
                ST_RD_F: begin
                    state_r <= ST_RD_FW;
                end
                ST_RD_FW: begin
                    state_r <= ST_LAT_F;
                end
                ST_LAT_F: begin
                    dec_r   <= mem.s_rdata ^ mem.e_rdata;
                    state_r <= ST_CHECK;
                end
                ST_CHECK: begin
`ifdef RC4_CHAR_CHECK_EN
                    if (is_plain_char(dec_r)) begin
                        d_wr_start_r <= 1'b1;
                        d_addr_r     <= k_r;
                        d_wr_data_r  <= dec_r;
                        state_r      <= ST_D_REQ;
                    end else begin
                        fail_r  <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= ST_END;
                    end
`else
                    d_wr_start_r <= 1'b1;
                    d_addr_r     <= k_r;
                    d_wr_data_r  <= dec_r;
                    state_r      <= ST_D_REQ;
`endif
                end
                ST_D_REQ: begin
                    state_r <= ST_D_WAIT;
                end
                ST_D_WAIT: begin
                    if (mem.d_wr_done) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_D_WAIT;
                    end
                end
                ST_NEXT: begin
                    if (k_r == K_LAST) begin
                        done_r  <= 1'b1;
                        state_r <= ST_END;
                    end else begin
                        k_r     <= k_r + MSG_AW'(1);
                        state_r <= ST_INC_I;
                    end
                end
                ST_END: begin
`ifdef RC4_CHAR_CHECK_EN
                    fail_r  <= 1'b0;
`endif
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.s_addr     = s_addr_r;
    assign mem.s_wdata    = s_wdata_r;
    assign mem.s_wren     = s_wren_r;
    assign mem.e_addr     = e_addr_r;
    assign mem.d_addr     = d_addr_r;
    assign mem.d_wr_data  = d_wr_data_r;
    assign mem.d_wr_start = d_wr_start_r;
    assign done           = done_r;
`ifdef RC4_CHAR_CHECK_EN
    assign fail           = fail_r;
`else
    assign fail           = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: behavioural S-RAM/ROM/D-memory and a textbook RC4 model.
`timescale 1ns/1ps
module tb_rc4_prga_decrypt;

    localparam int MSG_LEN = 32;
    localparam int MSG_AW  = 5;
`ifdef RC4_CHAR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset;
    logic start;
    logic done;
    logic fail;

    rc4_prga_decrypt_if #(.MSG_AW(MSG_AW)) mif ();

    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .start  (start),
        .done   (done),
        .fail   (fail),
        .mem    (mif)
    );

    always #5 clk = ~clk;

    // Behavioural memories
    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic       preload;
    logic [7:0] e_mem  [MSG_LEN];

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (mif.s_wren) begin
            s_mem[mif.s_addr] <= mif.s_wdata;
        end
        mif.s_rdata <= s_mem[mif.s_addr];
        mif.e_rdata <= e_mem[mif.e_addr];
    end

    // D-memory responder: d_wr_done pulses wr_dly cycles after d_wr_start
    int wr_dly;
    bit stray;
    initial begin
        int cnt;
        cnt = 0;
        mif.d_wr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!nreset) begin
                cnt = 0;
                mif.d_wr_done = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                mif.d_wr_done = (cnt == 0);
            end else begin
                mif.d_wr_done = stray;
                if (mif.d_wr_start === 1'b1) cnt = wr_dly;
            end
        end
    end

    // Monitor: logs D writes, counts done pulses, watches handshake hold rules
    logic [MSG_AW-1:0] wr_a_q [$];
    logic [7:0]        wr_d_q [$];
    int done_cnt, stab_err, dup_err;
    initial begin
        bit pend;
        logic [MSG_AW-1:0] ha;
        logic [7:0] hd;
        pend = 1'b0; ha = '0; hd = 8'd0;
        done_cnt = 0; stab_err = 0; dup_err = 0;
        forever begin
            @(posedge clk);
            #2;
            if (done === 1'b1) done_cnt++;
            if (!nreset) begin
                pend = 1'b0;
            end else if (mif.d_wr_start === 1'b1) begin
                if (pend) dup_err++;
                pend = 1'b1;
                ha = mif.d_addr;
                hd = mif.d_wr_data;
                wr_a_q.push_back(mif.d_addr);
                wr_d_q.push_back(mif.d_wr_data);
            end else if (pend) begin
                if (mif.d_addr !== ha || mif.d_wr_data !== hd) stab_err++;
                if (mif.d_wr_done === 1'b1) pend = 1'b0;
            end
        end
    end

    int n_asrt, n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({mif.s_addr, mif.s_wdata, mif.s_wren, mif.e_addr, mif.d_addr,
                    mif.d_wr_data, mif.d_wr_start, done, fail});
    endfunction

    // Reference model: RC4 PRGA on an array, plus expected plaintext queue
    logic [7:0] m_s [256];
    logic [7:0] exp_d [$];
    bit         exp_fail;

    function automatic bit plain(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    task automatic prga_step(inout int i, inout int j, output logic [7:0] f);
        logic [7:0] t;
        i = (i + 1) % 256;
        j = (j + int'(m_s[i])) % 256;
        t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        f = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
    endtask

    task automatic model_pass();
        int i, j;
        logic [7:0] f, d;
        i = 0; j = 0;
        exp_d.delete();
        exp_fail = 1'b0;
        for (int k = 0; k < MSG_LEN; k++) begin
            prga_step(i, j, f);
            d = f ^ e_mem[k];
            if (CHECK_EN && !plain(d)) begin
                exp_fail = 1'b1;
                break;
            end
            exp_d.push_back(d);
        end
    endtask

    // Fill E so that the pass from the current model S decrypts to letters/spaces
    task automatic make_plain_msg();
        logic [7:0] save [256];
        int i, j, r;
        logic [7:0] f, c;
        save = m_s;
        i = 0; j = 0;
        for (int k = 0; k < MSG_LEN; k++) begin
            prga_step(i, j, f);
            r = int'($urandom_range(26, 0));
            c = (r == 26) ? 8'h20 : (8'h61 + 8'(r));
            e_mem[k] = f ^ c;
        end
        m_s = save;
    endtask

    task automatic load_s(input bit rnd);
        int b;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        if (rnd) begin
            for (int a = 255; a > 0; a--) begin
                b = int'($urandom_range(a, 0));
                t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
            end
        end
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit got, output logic f);
        got = 1'b0; f = 1'b0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                f = fail;
            end
        end
    endtask

    task automatic wait_writes(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge clk);
            if (wr_a_q.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic check_writes(input string tag, input int lo);
        int bad;
        bad = 0;
        check({tag, "_nwr"}, wr_a_q.size() - lo, exp_d.size());
        for (int k = 0; k < exp_d.size(); k++) begin
            if (lo + k >= wr_a_q.size()) bad++;
            else if (wr_a_q[lo + k] !== MSG_AW'(k) || wr_d_q[lo + k] !== exp_d[k]) bad++;
        end
        check({tag, "_wrdata"}, bad, 0);
    endtask

    task automatic check_sram(input string tag);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== m_s[a]) bad++;
        check({tag, "_sram"}, bad, 0);
    endtask

    task automatic run_pass(input string tag, input int dly);
        int base, d0;
        bit got;
        logic f;
        wr_dly = dly;
        model_pass();
        base = wr_a_q.size();
        d0 = done_cnt;
        pulse_start();
        wait_done(4000, got, f);
        check({tag, "_done"}, got, 1);
        check({tag, "_fail"}, f, exp_fail);
        @(negedge clk);
        check({tag, "_ndone"}, done_cnt - d0, 1);
        check_writes(tag, base);
        check_sram(tag);
    endtask

    initial begin
        int base, d0, s0, d1;
        bit got, ok;
        logic f;
        n_asrt = 0; n_fail = 0;
        nreset = 1'b0; start = 1'b0; preload = 1'b0; stray = 1'b0; wr_dly = 1;
        for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'h00;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 64'd0);
        nreset = 1'b1;

        // Stray d_wr_done while idle is ignored
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_nowr", wr_a_q.size(), 0);
        check("stray_nodone", done_cnt, 0);

        // Identity S, zero E: keystream 0x02, 0x05, ...
        load_s(1'b0);
        for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'h00;
        wr_dly = 1;
        model_pass();
        base = wr_a_q.size();
        pulse_start();
`ifdef RC4_CHAR_CHECK_EN
        wait_done(500, got, f);
        check("abort_done", got, 1);
        check("abort_fail", f, 1);
        check("abort_s1", s_mem[1], 8'h01);
        check_writes("abort", base);
        check_sram("abort");
`else
        wait_writes(base + 2, 500, ok);
        check("ident_two_wr", ok, 1);
        check("ident_s2", s_mem[2], 8'h03);
        check("ident_s3", s_mem[3], 8'h02);
        check("ident_d0", wr_d_q[base], 8'h02);
        check("ident_d1", wr_d_q[base + 1], 8'h05);
        wait_done(2000, got, f);
        check("ident_done", got, 1);
        check("ident_fail", f, 0);
        check_writes("ident", base);
        check_sram("ident");
`endif
        repeat (3) @(negedge clk);

        // Identity S, E chosen to give "ab..."
        load_s(1'b0);
        make_plain_msg();
        e_mem[0] = 8'h02 ^ 8'h61;
        e_mem[1] = 8'h05 ^ 8'h62;
        base = wr_a_q.size();
        run_pass("ab", 1);
        check("ab_d0", wr_d_q[base], 8'h61);
        check("ab_d1", wr_d_q[base + 1], 8'h62);

        // Random permutations and random ciphertext
        for (int n = 0; n < 3; n++) begin
            load_s(1'b1);
            for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'($urandom);
            run_pass("rand", int'($urandom_range(3, 1)));
        end

        // Slow D-memory: outputs held through D_WAIT, one start per byte
        load_s(1'b1);
        make_plain_msg();
        s0 = stab_err;
        d1 = dup_err;
        run_pass("slow", 5);
        check("slow_stable", stab_err - s0, 0);
        check("slow_single_start", dup_err - d1, 0);

        // Reset during D_WAIT of byte 7, then a clean restart
        load_s(1'b0);
        make_plain_msg();
        wr_dly = 5;
        base = wr_a_q.size();
        pulse_start();
        wait_writes(base + 8, 2000, ok);
        check("rst_reach_b7", ok, 1);
        check("rst_b7_addr", wr_a_q[base + 7], 7);
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        check("rst_mid_outs", outs(), 64'd0);
        nreset = 1'b1;
        base = wr_a_q.size();
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("rst_no_wr", wr_a_q.size() - base, 0);
        check("rst_no_done", done_cnt - d0, 0);
        load_s(1'b0);
        make_plain_msg();
        run_pass("rst_restart", 2);

        // start held high across a pass, plus a mid-pass pulse
        load_s(1'b1);
        make_plain_msg();
        wr_dly = 1;
        model_pass();
        base = wr_a_q.size();
        d0 = done_cnt;
        @(negedge clk) start = 1'b1;
        wait_done(4000, got, f);
        check("held_p1_done", got, 1);
        check("held_p1_fail", f, exp_fail);
        check_writes("held_p1", base);
        base = wr_a_q.size();
        model_pass();
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(4000, got, f);
        check("held_p2_done", got, 1);
        check("held_p2_fail", f, exp_fail);
        @(negedge clk);
        check_writes("held_p2", base);
        check_sram("held_p2");
        s0 = wr_a_q.size();
        repeat (60) @(negedge clk);
        check("held_two_passes", done_cnt - d0, 2);
        check("held_idle_no_wr", wr_a_q.size() - s0, 0);

        check("hs_stable_all", stab_err, 0);
        check("hs_single_all", dup_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
